// File: rtl/dram_test_pkg.sv
// Shared types and LFSR feedback constants for the DRAM pattern tester.
package dram_test_pkg;

   typedef enum logic [1:0] {
      MODE_ADDR_HI = 2'd0,
      MODE_ADDR_LO = 2'd1,
      MODE_WALK1   = 2'd2,
      MODE_LFSR    = 2'd3
   } mode_e;

   typedef enum logic [3:0] {
      ST_IDLE, ST_WAIT_IDLE,
      ST_WR_REQ, ST_WR_WAIT, ST_WR_NEXT,
      ST_RD_REQ, ST_RD_WAIT, ST_RD_CHECK,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      PH_FILL       = 2'd0,
      PH_VERIFY     = 2'd1,
      PH_INV_FILL   = 2'd2,
      PH_INV_VERIFY = 2'd3
   } phase_e;

   // Right-shift Galois feedback masks, maximal-length polynomial per width.
   function automatic logic [31:0] lfsr_taps(input int unsigned w);
      case (w)
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         12:      return 32'h0000_0E08;
         16:      return 32'h0000_B400;
         24:      return 32'h00E1_0000;
         32:      return 32'h8020_0003;
         default: return (32'h1 << (w - 1)) | 32'h1;
      endcase
   endfunction

endpackage

// File: rtl/dram_pattern_gen.sv
// Pattern source: LFSR state plus a combinational mux of the per-address pattern,
// optionally inverted for the second pass.
module dram_pattern_gen
   import dram_test_pkg::*;
#(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned OFFSET    = 1,
   parameter logic [31:0] LFSR_SEED = 32'h1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              reseed_i,
   input  logic              step_i,
   input  mode_e             mode_i,
   input  logic              invert_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DATA_W-1:0] pattern_o
);

   localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));
   localparam logic [DATA_W-1:0] SEED = DATA_W'(LFSR_SEED);
   localparam logic [DATA_W-1:0] OFS  = DATA_W'(OFFSET);

   logic [DATA_W-1:0] lfsr_q, lfsr_d;
   logic [DATA_W-1:0] base;

   always_comb begin
      lfsr_d = lfsr_q;
      if (reseed_i)
         lfsr_d = SEED;
      else if (step_i)
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) lfsr_q <= SEED;
      else          lfsr_q <= lfsr_d;
   end

   // Address is widened to 64 bits so narrow ADDR_W still yields addr[15:8] = 0.
   always_comb begin
      base = '0;
      case (mode_i)
         MODE_ADDR_HI: base = DATA_W'((64'(addr_i) >> 8) & 64'hFF) + OFS;
         MODE_ADDR_LO: base = DATA_W'(64'(addr_i)) + OFS;
         MODE_WALK1:   base = DATA_W'(1) << (64'(addr_i) % 64'(DATA_W));
         MODE_LFSR:    base = lfsr_q;
         default:      base = '0;
      endcase
      pattern_o = invert_i ? ~base : base;
   end

endmodule

// File: rtl/dram_pattern_tester.sv
// DRAM self-test engine: fill / verify (optionally inverted) over the whole address
// range through a single-outstanding ena/ack/busy handshake; reports errors and first fail.
module dram_pattern_tester
   import dram_test_pkg::*;
#(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned OFFSET    = 1,
   parameter logic [31:0] LFSR_SEED = 32'h1,
   parameter int unsigned ERR_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic              invert_pass_i,
   input  logic              loop_i,
   input  logic              stop_on_err_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_write_o,
   output logic              mem_ena_o,
   output logic [DATA_W-1:0] mem_wr_data_o,
   input  logic              mem_ack_i,
   input  logic              mem_busy_i,
   input  logic [DATA_W-1:0] mem_rd_data_i,
   output logic              running_o,
   output logic [1:0]        phase_o,
   output logic              error_o,
   output logic [ERR_W-1:0]  err_cnt_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [DATA_W-1:0] fail_exp_o,
   output logic [DATA_W-1:0] fail_got_o,
   output logic [15:0]       pass_cnt_o
);

   state_e            state_q, state_d;
   phase_e            phase_q, phase_d;
   mode_e             mode_q, mode_d;
   logic              inv_q, inv_d, soe_q, soe_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ena_q, ena_d, write_q, write_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rd_q, rd_d;
   logic              error_q, error_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;
   logic [15:0]       pass_cnt_q, pass_cnt_d;

   logic              reseed, step, mismatch;
   logic [DATA_W-1:0] pattern;

   dram_pattern_gen #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET(OFFSET), .LFSR_SEED(LFSR_SEED)
   ) u_gen (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .reseed_i(reseed), .step_i(step),
      .mode_i(mode_q), .invert_i(phase_q[1]), .addr_i(addr_q), .pattern_o(pattern)
   );

   assign mismatch = (rd_q != pattern);

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      mode_d      = mode_q;
      inv_d       = inv_q;
      soe_d       = soe_q;
      addr_d      = addr_q;
      ena_d       = ena_q;
      write_d     = write_q;
      maddr_d     = maddr_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      error_d     = error_q;
      err_cnt_d   = err_cnt_q;
      fail_addr_d = fail_addr_q;
      fail_exp_d  = fail_exp_q;
      fail_got_d  = fail_got_q;
      pass_cnt_d  = pass_cnt_q;
      reseed      = 1'b0;
      step        = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               mode_d      = mode_e'(mode_i);
               inv_d       = invert_pass_i;
               soe_d       = stop_on_err_i;
               error_d     = 1'b0;
               err_cnt_d   = '0;
               fail_addr_d = '0;
               fail_exp_d  = '0;
               fail_got_d  = '0;
               phase_d     = PH_FILL;
               addr_d      = '0;
               reseed      = 1'b1;
               state_d     = ST_WAIT_IDLE;
            end else if (state_q == ST_DONE && loop_i) begin
               // Soak restart keeps the error record accumulated so far.
               pass_cnt_d = pass_cnt_q + 16'd1;
               phase_d    = PH_FILL;
               addr_d     = '0;
               reseed     = 1'b1;
               state_d    = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: if (!mem_busy_i) state_d = ST_WR_REQ;
         ST_WR_REQ, ST_RD_REQ: begin
            // Bus fields load only as ena rises, so they stay frozen until the ack.
            if (!ena_q) begin
               ena_d   = 1'b1;
               maddr_d = addr_q;
               write_d = (state_q == ST_WR_REQ);
               wdata_d = (state_q == ST_WR_REQ) ? pattern : '0;
            end else if (mem_ack_i) begin
               ena_d   = 1'b0;
               state_d = (state_q == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
            end
         end
         ST_WR_WAIT: if (!mem_busy_i) state_d = ST_WR_NEXT;
         ST_WR_NEXT: begin
            if (addr_q != '1) begin
               addr_d  = addr_q + 1'b1;
               step    = 1'b1;
               state_d = ST_WR_REQ;
            end else begin
               addr_d  = '0;
               reseed  = 1'b1;
               phase_d = phase_e'(phase_q + 2'd1);
               state_d = ST_RD_REQ;
            end
         end
         ST_RD_WAIT: begin
            if (!mem_busy_i) begin
               rd_d    = mem_rd_data_i;
               state_d = ST_RD_CHECK;
            end
         end
         ST_RD_CHECK: begin
            if (mismatch) begin
               error_d = 1'b1;
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
               if (!error_q) begin
                  fail_addr_d = addr_q;
                  fail_exp_d  = pattern;
                  fail_got_d  = rd_q;
               end
            end
            if (mismatch && soe_q) begin
               state_d = ST_DONE;
            end else if (addr_q != '1) begin
               addr_d  = addr_q + 1'b1;
               step    = 1'b1;
               state_d = ST_RD_REQ;
            end else begin
               addr_d = '0;
               reseed = 1'b1;
               if (inv_q && phase_q == PH_VERIFY) begin
                  phase_d = PH_INV_FILL;
                  state_d = ST_WR_REQ;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         phase_q     <= PH_FILL;
         mode_q      <= MODE_ADDR_HI;
         inv_q       <= 1'b0;
         soe_q       <= 1'b0;
         addr_q      <= '0;
         ena_q       <= 1'b0;
         write_q     <= 1'b0;
         maddr_q     <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         error_q     <= 1'b0;
         err_cnt_q   <= '0;
         fail_addr_q <= '0;
         fail_exp_q  <= '0;
         fail_got_q  <= '0;
         pass_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         mode_q      <= mode_d;
         inv_q       <= inv_d;
         soe_q       <= soe_d;
         addr_q      <= addr_d;
         ena_q       <= ena_d;
         write_q     <= write_d;
         maddr_q     <= maddr_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         error_q     <= error_d;
         err_cnt_q   <= err_cnt_d;
         fail_addr_q <= fail_addr_d;
         fail_exp_q  <= fail_exp_d;
         fail_got_q  <= fail_got_d;
         pass_cnt_q  <= pass_cnt_d;
      end
   end

   assign mem_addr_o    = maddr_q;
   assign mem_write_o   = write_q;
   assign mem_ena_o     = ena_q;
   assign mem_wr_data_o = wdata_q;
   assign running_o     = !(state_q == ST_IDLE || state_q == ST_DONE);
   assign phase_o       = phase_q;
   assign error_o       = error_q;
   assign err_cnt_o     = err_cnt_q;
   assign fail_addr_o   = fail_addr_q;
   assign fail_exp_o    = fail_exp_q;
   assign fail_got_o    = fail_got_q;
   assign pass_cnt_o    = pass_cnt_q;

endmodule

// File: tb/tb_dram_pattern_tester.sv
// Scoreboard bench: behavioural DRAM controller with random ack/busy delays and refresh
// stalls; expected accesses and end-of-run status are queued at issue and popped by a monitor.
module tb_dram_pattern_tester;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int EW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, start, inv, loop_en, soe;
   logic [1:0]    mode;
   logic [AW-1:0] mem_addr, fail_addr;
   logic          mem_write, mem_ena, ack, busy, running, error;
   logic [DW-1:0] mem_wr_data, rd_data, fail_exp, fail_got;
   logic [1:0]    phase;
   logic [EW-1:0] err_cnt;
   logic [15:0]   pass_cnt;

   dram_pattern_tester #(
      .ADDR_W(AW), .DATA_W(DW), .OFFSET(1), .LFSR_SEED(32'h1), .ERR_W(EW)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mode_i(mode),
      .invert_pass_i(inv), .loop_i(loop_en), .stop_on_err_i(soe),
      .mem_addr_o(mem_addr), .mem_write_o(mem_write), .mem_ena_o(mem_ena),
      .mem_wr_data_o(mem_wr_data), .mem_ack_i(ack), .mem_busy_i(busy),
      .mem_rd_data_i(rd_data), .running_o(running), .phase_o(phase),
      .error_o(error), .err_cnt_o(err_cnt), .fail_addr_o(fail_addr),
      .fail_exp_o(fail_exp), .fail_got_o(fail_got), .pass_cnt_o(pass_cnt)
   );

   typedef struct {bit wr; int addr; int data; int ph;} acc_t;
   typedef struct {int err; int cnt; int fa; int fe; int fg; int pc;} st_t;

   acc_t exp_acc[$];
   st_t  exp_st[$];
   int   w3[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   hold = 1'b0;
   logic [DW-1:0] mem   [16];
   logic [DW-1:0] stuck [16];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] lstep(input logic [7:0] l);
      return l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
   endfunction

   function automatic logic [7:0] pat(input int m, input int a, input logic [7:0] l);
      case (m)
         0:       return 8'h01;            // addr[15:8] is zero for a 4-bit address
         1:       return 8'(a + 1);
         2:       return 8'h01 << (a % 8);
         default: return l;
      endcase
   endfunction

   // Queue the accesses of one run; stop_a >= 0 ends the run after that verify read.
   task automatic push_run(input int m, input bit iv, input int stop_a);
      logic [7:0] l, p;
      acc_t e;
      for (int ph = 0; ph < (iv ? 4 : 2); ph++) begin
         l = 8'h01;
         for (int a = 0; a < 16; a++) begin
            p = pat(m, a, l);
            if (ph >= 2) p = ~p;
            e.wr   = (ph % 2 == 0);
            e.addr = a;
            e.data = e.wr ? int'(p) : 0;
            e.ph   = ph;
            exp_acc.push_back(e);
            if (ph == 1 && a == stop_a) return;
            l = lstep(l);
         end
      end
   endtask

   task automatic push_st(input int err, input int cnt, input int fa, input int fe,
                          input int fg, input int pc);
      st_t s;
      s.err = err; s.cnt = cnt; s.fa = fa; s.fe = fe; s.fg = fg; s.pc = pc;
      exp_st.push_back(s);
   endtask

   task automatic do_start(input int m, input bit iv, input bit s, input bit lp);
      @(negedge clk);
      mode = 2'(m); inv = iv; soe = s; loop_en = lp; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while (cyc < 6000 && !(exp_acc.size() == 0 && exp_st.size() == 0 && !running)) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 6000) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: run did not finish, %0d accesses and %0d status checks still required",
                  name, exp_acc.size(), exp_st.size());
         exp_acc.delete();
         exp_st.delete();
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ena"},      32'(mem_ena), 0);
      chk({tag, "_addr"},     32'(mem_addr), 0);
      chk({tag, "_write"},    32'(mem_write), 0);
      chk({tag, "_wdata"},    32'(mem_wr_data), 0);
      chk({tag, "_running"},  32'(running), 0);
      chk({tag, "_phase"},    32'(phase), 0);
      chk({tag, "_error"},    32'(error), 0);
      chk({tag, "_errcnt"},   32'(err_cnt), 0);
      chk({tag, "_failaddr"}, 32'(fail_addr), 0);
      chk({tag, "_failexp"},  32'(fail_exp), 0);
      chk({tag, "_failgot"},  32'(fail_got), 0);
      chk({tag, "_passcnt"},  32'(pass_cnt), 0);
   endtask

   task automatic clear_stuck();
      for (int i = 0; i < 16; i++) stuck[i] = '0;
   endtask

   // Behavioural controller: inputs change on the falling edge only.
   initial begin
      logic [3:0] a;
      logic       w;
      ack = 1'b0; busy = 1'b0; rd_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ack = 1'b0; busy = 1'b0;
         end else if ($urandom_range(0, 11) == 0) begin
            busy = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            busy = 1'b0;
         end else if (mem_ena && !hold) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ack = 1'b1; busy = 1'b1;
            a = mem_addr; w = mem_write;
            if (w) mem[a] = mem_wr_data;
            @(negedge clk);
            ack = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (!w) rd_data = mem[a] & ~stuck[a];
            busy = 1'b0;
         end
      end
   end

   // Monitor: accepted accesses and end-of-run status against the queues.
   initial begin
      bit   prev_run = 1'b0;
      acc_t e;
      st_t  s;
      forever begin
         @(posedge clk);
         #2;
         if (ack) begin
            if (exp_acc.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_access: got addr %0d write %0b, required none",
                        mem_addr, mem_write);
            end else begin
               e = exp_acc.pop_front();
               chk("acc_write", 32'(mem_write), 32'(e.wr));
               chk("acc_addr",  32'(mem_addr), e.addr);
               if (e.wr) chk("acc_wdata", 32'(mem_wr_data), e.data);
               chk("acc_phase", 32'(phase), e.ph);
            end
            if (mem_write && mem_addr == 4'd3) w3.push_back(int'(mem_wr_data));
         end
         if (rst_n && prev_run && !running) begin
            if (exp_st.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got end of run, required none");
            end else begin
               s = exp_st.pop_front();
               chk("st_error",    32'(error), s.err);
               chk("st_errcnt",   32'(err_cnt), s.cnt);
               chk("st_failaddr", 32'(fail_addr), s.fa);
               chk("st_failexp",  32'(fail_exp), s.fe);
               chk("st_failgot",  32'(fail_got), s.fg);
               chk("st_passcnt",  32'(pass_cnt), s.pc);
            end
         end
         prev_run = running;
      end
   end

   initial begin
      int cyc;
      rst_n = 1'b0; start = 1'b0; mode = 2'd0; inv = 1'b0; loop_en = 1'b0; soe = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      clear_stuck();
      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ADDR_LO on clean memory
      push_run(1, 1'b0, -1); push_st(0, 0, 0, 0, 0, 0);
      do_start(1, 1'b0, 1'b0, 1'b0);
      wait_done("addr_lo_clean");

      // WALK1 with inverted pass
      w3.delete();
      push_run(2, 1'b1, -1); push_st(0, 0, 0, 0, 0, 0);
      do_start(2, 1'b1, 1'b0, 1'b0);
      wait_done("walk1_inv");
      chk("walk1_addr3_writes", 32'(w3.size()), 2);
      if (w3.size() >= 2) begin
         chk("walk1_addr3_fill",    32'(w3[0]), 32'h08);
         chk("walk1_addr3_invfill", 32'(w3[1]), 32'hF7);
      end

      // bit 2 stuck at 0 at address 5
      stuck[5] = 8'h04;
      push_run(1, 1'b0, -1); push_st(1, 1, 5, 6, 2, 0);
      do_start(1, 1'b0, 1'b0, 1'b0);
      wait_done("stuck_bit");

      // same fault, halt on first mismatch
      push_run(1, 1'b0, 5); push_st(1, 1, 5, 6, 2, 0);
      do_start(1, 1'b0, 1'b1, 1'b0);
      wait_done("stop_on_err");
      repeat (20) @(negedge clk);
      chk("stop_idle_ena", 32'(mem_ena), 0);
      clear_stuck();

      // ADDR_HI, start clears the previous fail record
      push_run(0, 1'b0, -1); push_st(0, 0, 0, 0, 0, 0);
      do_start(0, 1'b0, 1'b0, 1'b0);
      wait_done("addr_hi_clean");

      // every bit stuck: 16 mismatches saturate a 4-bit counter
      for (int i = 0; i < 16; i++) stuck[i] = 8'hFF;
      push_run(3, 1'b0, -1); push_st(1, 15, 0, 1, 0, 0);
      do_start(3, 1'b0, 1'b0, 1'b0);
      wait_done("lfsr_all_stuck");
      clear_stuck();

      // LFSR soak: loop until pass_cnt reaches 3, then let the last run halt
      for (int r = 0; r < 4; r++) begin
         push_run(3, 1'b0, -1); push_st(0, 0, 0, 0, 0, r);
      end
      do_start(3, 1'b0, 1'b0, 1'b1);
      cyc = 0;
      while (cyc < 5000 && pass_cnt != 16'd3) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 5000) begin
         n_cmp++; n_bad++;
         $display("FAIL loop_passcnt: got %0d, required 3", pass_cnt);
      end
      loop_en = 1'b0;
      wait_done("lfsr_loop");
      chk("loop_final_passcnt", 32'(pass_cnt), 3);

      // async reset while a write request is pending
      hold = 1'b1;
      do_start(1, 1'b0, 1'b0, 1'b0);
      cyc = 0;
      while (cyc < 200 && !mem_ena) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_ena_seen", 32'(mem_ena), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("abort");
      hold = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      push_run(1, 1'b0, -1); push_st(0, 0, 0, 0, 0, 0);
      do_start(1, 1'b0, 1'b0, 1'b0);
      wait_done("rerun_after_reset");

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
